adain_seq_ctrl: RTL

- Sequencer for the top_adain core. Per channel, it loads style coefficients (ys, yb) from a style RAM.
- It then streams one N×N feature-map channel from an external buffer into the core twice:
  - scan pass, start=2'b01
  - normalize pass, start=2'b10
- It loops over C channels, tags normalized outputs with channel and pixel index, and pulses frame_done at the end.

---
 rtl/adain_seq_ctrl.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/adain_seq_ctrl.sv
// rtl/adain_seq_ctrl.sv - per-channel scan/normalize sequencer for the top_adain core
// Optional feature macro: ADAIN_SEQ_TIMEOUT_EN (watchdog in WAIT_STAT/DRAIN, limit TIMEOUT_CYC)
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_cfg_start, i_cfg_n, i_cfg_c   frame start pulse with spatial size N and channel count C
//   o_busy, o_frame_done, o_err     frame status (err is sticky until next accepted start)
//   o_fm_rd_*, i_fm_rd_data         feature-map buffer read port (1-cycle read latency)
//   o_sty_rd_*, i_sty_ys/yb         style RAM read port (1-cycle read latency)
//   o_adain_*, i_adain_out/done     core control, pixel, coefficients and status
//   o_out_valid/data/ch/idx         tagged normalized output stream
module adain_seq_ctrl #(
    parameter int WIDTH_IN    = 48,
    parameter int WIDTH_OUT   = 16,
    parameter int N_MAX       = 128,
    parameter int C_MAX       = 512,
    parameter int GAP         = 2,
    parameter int PIPE_LAT    = 5,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst_n,
    input  logic                                      i_cfg_start,
    input  logic [$clog2(N_MAX+1)-1:0]                i_cfg_n,
    input  logic [$clog2(C_MAX+1)-1:0]                i_cfg_c,
    output logic                                      o_busy,
    output logic                                      o_frame_done,
    output logic                                      o_err,
    output logic                                      o_fm_rd_en,
    output logic [$clog2(C_MAX*N_MAX*N_MAX)-1:0]      o_fm_rd_addr,
    input  logic [WIDTH_IN-1:0]                       i_fm_rd_data,
    output logic                                      o_sty_rd_en,
    output logic [$clog2(C_MAX)-1:0]                  o_sty_rd_addr,
    input  logic [WIDTH_IN-1:0]                       i_sty_ys,
    input  logic [WIDTH_IN-1:0]                       i_sty_yb,
    output logic                                      o_adain_en,
    output logic [1:0]                                o_adain_start,
    output logic [$clog2(N_MAX+1)-1:0]                o_adain_n,
    output logic [WIDTH_IN-1:0]                       o_adain_in,
    output logic [WIDTH_IN-1:0]                       o_adain_ys,
    output logic [WIDTH_IN-1:0]                       o_adain_yb,
    input  logic [WIDTH_OUT-1:0]                      i_adain_out,
    input  logic [1:0]                                i_adain_done,
    output logic                                      o_out_valid,
    output logic [WIDTH_OUT-1:0]                      o_out_data,
    output logic [$clog2(C_MAX)-1:0]                  o_out_ch,
    output logic [$clog2(N_MAX*N_MAX)-1:0]            o_out_idx
);
    localparam int NW  = $clog2(N_MAX + 1);
    localparam int CW  = $clog2(C_MAX + 1);
    localparam int AW  = $clog2(C_MAX * N_MAX * N_MAX);
    localparam int CHW = $clog2(C_MAX);
    localparam int IW  = $clog2(N_MAX * N_MAX);
    localparam int NNW = $clog2(N_MAX * N_MAX + 1);
    localparam int SW  = $clog2(GAP + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_STY, S_LATCH_STY, S_SCAN, S_WAIT_STAT, S_NORM, S_DRAIN, S_NEXT_CH
    } state_t;

    state_t               r_state, w_next;
    logic [NW-1:0]        r_n;
    logic [CW-1:0]        r_c;
    logic [NNW-1:0]       r_nn;
    logic [CHW-1:0]       r_ch;
    logic [AW-1:0]        r_base;
    logic [IW-1:0]        r_idx;
    logic [SW-1:0]        r_slot;
    logic [WIDTH_IN-1:0]  r_adain_in, r_ys, r_yb;
    logic                 r_frame_done, r_err;
    logic [PIPE_LAT-1:0]  r_tag_v;
    logic [IW-1:0]        r_tag_idx [PIPE_LAT];
    logic                 r_out_valid;
    logic [WIDTH_OUT-1:0] r_out_data;
    logic [CHW-1:0]       r_out_ch;
    logic [IW-1:0]        r_out_idx;

    logic       w_fm_rd_en, w_sty_rd_en, w_hold_en, w_timeout;
    logic [1:0] w_start;

    wire w_cfg_bad   = (i_cfg_n > NW'(N_MAX)) || (i_cfg_c > CW'(C_MAX));
    wire w_cfg_zero  = (i_cfg_n == '0) || (i_cfg_c == '0);
    wire w_in_pass   = (r_state == S_SCAN) || (r_state == S_NORM);
    wire w_slot_last = (r_slot == SW'(GAP + 1));
    wire w_idx_last  = (NNW'(r_idx) == (r_nn - NNW'(1)));
    wire w_pass_end  = w_in_pass && w_slot_last && w_idx_last;
    // Slot cycle 1 is the core enable cycle; read data arrives that same cycle.
    wire w_pulse     = w_in_pass && (r_slot == SW'(1));
    wire w_ch_last   = (CW'(r_ch) == (r_c - CW'(1)));
    wire w_tags_empty = (r_tag_v == '0);

    always_comb begin
        w_next      = r_state;
        w_fm_rd_en  = 1'b0;
        w_sty_rd_en = 1'b0;
        w_start     = 2'b00;
        w_hold_en   = 1'b0;
        case (r_state)
            S_IDLE:      if (i_cfg_start && !w_cfg_bad && !w_cfg_zero) w_next = S_LOAD_STY;
            S_LOAD_STY: begin
                w_sty_rd_en = 1'b1;
                w_next      = S_LATCH_STY;
            end
            S_LATCH_STY: w_next = S_SCAN;
            S_SCAN: begin
                w_start    = 2'b01;
                w_fm_rd_en = (r_slot == '0);
                if (w_pass_end) w_next = S_WAIT_STAT;
            end
            S_WAIT_STAT: begin
                w_hold_en = 1'b1;
                if (i_adain_done == 2'b01) w_next = S_NORM;
            end
            S_NORM: begin
                w_start    = 2'b10;
                w_fm_rd_en = (r_slot == '0);
                if (w_pass_end) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                w_hold_en = 1'b1;
                if (i_adain_done == 2'b11 && w_tags_empty) w_next = S_NEXT_CH;
            end
            S_NEXT_CH:   w_next = w_ch_last ? S_IDLE : S_LOAD_STY;
            default:     w_next = S_IDLE;
        endcase
        if (w_timeout) begin
            w_next    = S_IDLE;
            w_hold_en = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_n          <= '0;
            r_c          <= '0;
            r_nn         <= '0;
            r_ch         <= '0;
            r_base       <= '0;
            r_idx        <= '0;
            r_slot       <= '0;
            r_adain_in   <= '0;
            r_ys         <= '0;
            r_yb         <= '0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_frame_done <= 1'b0;
            if (w_pulse) r_adain_in <= i_fm_rd_data;
            case (r_state)
                S_IDLE: begin
                    if (i_cfg_start) begin
                        if (w_cfg_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_err <= 1'b0;
                            if (w_cfg_zero) begin
                                r_frame_done <= 1'b1;
                            end else begin
                                r_n    <= i_cfg_n;
                                r_c    <= i_cfg_c;
                                r_nn   <= NNW'(i_cfg_n) * NNW'(i_cfg_n);
                                r_ch   <= '0;
                                r_base <= '0;
                                r_idx  <= '0;
                                r_slot <= '0;
                            end
                        end
                    end
                end
                S_LATCH_STY: begin
                    r_ys <= i_sty_ys;
                    r_yb <= i_sty_yb;
                end
                S_SCAN, S_NORM: begin
                    if (w_slot_last) begin
                        r_slot <= '0;
                        r_idx  <= w_idx_last ? '0 : r_idx + IW'(1);
                    end else begin
                        r_slot <= r_slot + SW'(1);
                    end
                end
                S_NEXT_CH: begin
                    if (w_ch_last) begin
                        r_frame_done <= 1'b1;
                    end else begin
                        r_ch   <= r_ch + CHW'(1);
                        r_base <= r_base + AW'(r_nn);
                    end
                end
                default: ;
            endcase
            if (w_timeout) r_err <= 1'b1;
        end
    end

    // Tag pipeline mirrors the core latency so each output carries its pixel index.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tag_v     <= '0;
            for (int i = 0; i < PIPE_LAT; i++) r_tag_idx[i] <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_idx   <= '0;
        end else begin
            r_tag_v[0]   <= w_pulse && (r_state == S_NORM);
            r_tag_idx[0] <= r_idx;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_tag_v[i]   <= r_tag_v[i-1];
                r_tag_idx[i] <= r_tag_idx[i-1];
            end
            r_out_valid <= r_tag_v[PIPE_LAT-1];
            if (r_tag_v[PIPE_LAT-1]) begin
                r_out_data <= i_adain_out;
                r_out_idx  <= r_tag_idx[PIPE_LAT-1];
                r_out_ch   <= r_ch;
            end
        end
    end

`ifdef ADAIN_SEQ_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);
    logic [WDW-1:0] r_wd;
    wire w_wd_state = (r_state == S_WAIT_STAT) || (r_state == S_DRAIN);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                              r_wd <= '0;
        else if (w_wd_state && (w_next == r_state)) r_wd <= r_wd + WDW'(1);
        else                                       r_wd <= '0;
    end

    assign w_timeout = w_wd_state && (r_wd == WDW'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    assign o_busy        = (r_state != S_IDLE);
    assign o_frame_done  = r_frame_done;
    assign o_err         = r_err;
    assign o_fm_rd_en    = w_fm_rd_en;
    assign o_fm_rd_addr  = r_base + AW'(r_idx);
    assign o_sty_rd_en   = w_sty_rd_en;
    assign o_sty_rd_addr = r_ch;
    assign o_adain_en    = w_pulse | w_hold_en;
    assign o_adain_start = w_start;
    assign o_adain_n     = r_n;
    assign o_adain_in    = w_pulse ? i_fm_rd_data : r_adain_in;
    assign o_adain_ys    = r_ys;
    assign o_adain_yb    = r_yb;
    assign o_out_valid   = r_out_valid;
    assign o_out_data    = r_out_data;
    assign o_out_ch      = r_out_ch;
    assign o_out_idx     = r_out_idx;
endmodule
